// File: rtl/cmp_arb.sv
`default_nettype none
// ============================================================================
// Module   : cmp_arb
// Purpose  : Round-robin arbiter/sequencer that shares one pipelined
//            comparator among N_REQ requesters. It accepts one request at a
//            time, launches the comparator and returns the result tagged with
//            the requester id.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_arb #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*WIDTH-1:0]     req_a_i,
  input  logic [N_REQ*WIDTH-1:0]     req_b_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [WIDTH-1:0]           cmp_in_a_o,
  output logic [WIDTH-1:0]           cmp_in_b_o,
  output logic                       cmp_start_o,
  input  logic                       cmp_out_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic                       rsp_gt_o,
  input  logic                       rsp_ready_i,
  output logic                       busy_o
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = $clog2(CMP_LAT + 1);

  localparam logic [IDW:0]      C_NREQ = (IDW + 1)'(N_REQ);
  localparam logic [IDW-1:0]    C_LAST = IDW'(N_REQ - 1);
  localparam logic [CNTW-1:0]   C_LAT  = CNTW'(CMP_LAT);
  localparam logic [CNTW-1:0]   C_ONE  = CNTW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic             cmp_start_q, cmp_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_gt_q, rsp_gt_d;
  logic             busy_q, busy_d;

  logic             w_found;
  logic [IDW-1:0]   w_win_id;
  logic [IDW:0]     w_sum;
  logic [WIDTH-1:0] w_win_a;
  logic [WIDTH-1:0] w_win_b;

  // Round-robin search: first set req_valid bit starting at rr_ptr, wrapping mod N_REQ
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
      if (w_sum >= C_NREQ) begin
        w_sum = w_sum - C_NREQ;
      end
      if (!w_found && req_valid_i[w_sum[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_win_id = w_sum[IDW-1:0];
      end
    end
  end

  assign w_win_a = req_a_i[w_win_id*WIDTH +: WIDTH];
  assign w_win_b = req_b_i[w_win_id*WIDTH +: WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == C_ONE) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; req_ready is the only combinational output
  always_comb begin
    req_ready_o = '0;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_start_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_gt_d    = rsp_gt_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          req_ready_o = N_REQ'(1) << w_win_id;
          id_d        = w_win_id;
          cmp_a_d     = w_win_a;
          cmp_b_d     = w_win_b;
          cmp_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = C_LAT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          // Last comparator cycle: capture result, drop operands, present response
          rsp_gt_d    = cmp_out_i;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          cmp_a_d     = '0;
          cmp_b_d     = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rr_ptr_d = (id_q == C_LAST) ? '0 : id_q + 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Registered outputs and datapath; reset clears everything and aborts any request
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_start_q <= cmp_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gt_q    <= rsp_gt_d;
      busy_q      <= busy_d;
    end
  end

  assign cmp_in_a_o  = cmp_a_q;
  assign cmp_in_b_o  = cmp_b_q;
  assign cmp_start_o = cmp_start_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_gt_o    = rsp_gt_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
